// File: rtl/featuremap_pkg.sv
// Shared constants, FP32 field layout and helpers for the featuremap
// reduction/activation datapath.
package featuremap_pkg;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;
  localparam int ACT_LEAKY  = 2;

  localparam int FP32_SIGN_POS = 31;
  localparam int FP32_EXP_POS  = 23;
  localparam int FP32_EXP_W    = FP32_SIGN_POS - FP32_EXP_POS;
  localparam int FP32_MAN_W    = FP32_EXP_POS;

  localparam logic [31:0]           FP32_ZERO    = 32'h0000_0000;
  localparam logic [31:0]           FP32_QNAN    = 32'h7fc0_0000;
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = '1;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

  // Number of adder-tree levels needed to reduce n lanes to one.
  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single adder: round-to-nearest-even, denormals
// flushed to zero on both inputs and output.
module fp32_add
  import featuremap_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  fp32_t              fa, fb, op_hi, op_lo;
  logic [7:0]         shift;
  logic [53:0]        wide;
  logic [26:0]        m_hi, m_lo, diff, norm;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic [24:0]        rounded;
  logic signed [9:0]  exp_r;
  logic               rnd_up;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  always_comb begin
    fa      = a;
    fb      = b;
    op_hi   = fa;
    op_lo   = fb;
    shift   = '0;
    wide    = '0;
    m_hi    = '0;
    m_lo    = '0;
    diff    = '0;
    norm    = '0;
    sum     = '0;
    lz      = '0;
    rounded = '0;
    exp_r   = '0;
    rnd_up  = 1'b0;
    y       = FP32_ZERO;

    if (fa.exp == FP32_EXP_MAX || fb.exp == FP32_EXP_MAX) begin
      if ((fa.exp == FP32_EXP_MAX && fa.man != '0) ||
          (fb.exp == FP32_EXP_MAX && fb.man != '0))
        y = FP32_QNAN;
      else if (fa.exp == FP32_EXP_MAX && fb.exp == FP32_EXP_MAX && fa.sign != fb.sign)
        y = FP32_QNAN;
      else if (fa.exp == FP32_EXP_MAX)
        y = a;
      else
        y = b;
    end else if (fa.exp == '0 && fb.exp == '0) begin
      y = {fa.sign & fb.sign, 31'b0};
    end else if (fa.exp == '0) begin
      y = b;
    end else if (fb.exp == '0) begin
      y = a;
    end else begin
      if ({fb.exp, fb.man} > {fa.exp, fa.man}) begin
        op_hi = fb;
        op_lo = fa;
      end
      shift = op_hi.exp - op_lo.exp;
      m_hi  = {1'b1, op_hi.man, 3'b000};
      // Bits shifted past the guard/round positions collapse into sticky.
      wide  = {1'b1, op_lo.man, 3'b000, 27'b0} >> shift;
      m_lo  = wide[53:27] | {26'b0, |wide[26:0]};

      if (op_hi.sign == op_lo.sign) begin
        sum = {1'b0, m_hi} + {1'b0, m_lo};
        if (sum[27]) begin
          norm  = {sum[27:2], sum[1] | sum[0]};
          exp_r = $signed({2'b00, op_hi.exp}) + 10'sd1;
        end else begin
          norm  = sum[26:0];
          exp_r = $signed({2'b00, op_hi.exp});
        end
      end else begin
        diff  = m_hi - m_lo;
        lz    = lzc27(diff);
        norm  = diff << lz;
        exp_r = $signed({2'b00, op_hi.exp}) - $signed({5'b00000, lz});
      end

      rnd_up  = norm[2] & (norm[3] | norm[1] | norm[0]);
      rounded = {1'b0, norm[26:3]} + {24'b0, rnd_up};
      if (rounded[24]) exp_r = exp_r + 10'sd1;

      if (norm == '0)
        y = FP32_ZERO;
      else if (exp_r <= 10'sd0)
        y = {op_hi.sign, 31'b0};
      else if (exp_r >= 10'sd255)
        y = {op_hi.sign, FP32_EXP_MAX, 23'b0};
      else
        y = {op_hi.sign, exp_r[7:0], rounded[24] ? rounded[23:1] : rounded[22:0]};
    end
  end

endmodule

// File: rtl/featuremap_reduce_act.sv
// Channel reduction (pipelined FP32 adder tree), bias add and activation for
// one output-feature-map pixel per cycle, with valid/ready and frame marker.
module featuremap_reduce_act
  import featuremap_pkg::*;
#(
  parameter int          CH_IN       = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          IMG_SIZE    = 104,
  parameter logic [31:0] BIAS        = 32'h0000_0000,
  parameter int          ACT_MODE    = ACT_LEAKY,
  parameter int          LEAKY_SHIFT = 3
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [CH_IN*DATA_WIDTH-1:0] data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        last_out
);

  localparam int LEVELS = tree_levels(CH_IN);
  localparam int NP     = 1 << LEVELS;
  localparam int FRAME  = IMG_SIZE * IMG_SIZE;
  localparam int CNT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME - 1);

  logic                  en;
  logic [DATA_WIDTH-1:0] bias_c;
  logic [DATA_WIDTH-1:0] sum_p1;
  logic                  vld_p1;
  logic [CNT_W-1:0]      pix_cnt;

  // A stalled output freezes every stage; an empty output lets the pipe fill.
  assign en        = !valid_out || ready_in;
  assign ready_out = en;

  function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] x);
    fp32_t v;
    v = x;
    if (v.exp != FP32_EXP_MAX && v.sign) begin
      if (ACT_MODE == ACT_RELU) begin
        v = FP32_ZERO;
      end else if (ACT_MODE == ACT_LEAKY) begin
        if (v.exp > FP32_EXP_W'(LEAKY_SHIFT))
          v.exp = v.exp - FP32_EXP_W'(LEAKY_SHIFT);
        else
          v = FP32_ZERO;
      end
    end
    return v;
  endfunction

  genvar lv, k;
  generate
    for (lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      localparam int NODES = NP >> lv;
      logic [NODES*DATA_WIDTH-1:0] node_p0;
      logic                        vld_p0;

      if (lv == 0) begin : g_in
        // Lanes beyond CH_IN are padded with +0.0.
        always_comb begin
          node_p0 = '0;
          node_p0[CH_IN*DATA_WIDTH-1:0] = data_in;
        end
        assign vld_p0 = valid_in;
      end else begin : g_add
        logic [NODES*DATA_WIDTH-1:0] sum_c;

        for (k = 0; k < NODES; k++) begin : g_node
          fp32_add u_add (
            .a (g_lvl[lv-1].node_p0[(2*k)*DATA_WIDTH   +: DATA_WIDTH]),
            .b (g_lvl[lv-1].node_p0[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]),
            .y (sum_c[k*DATA_WIDTH +: DATA_WIDTH])
          );
        end

        // ---- tree level register ----
        always_ff @(posedge Clk) begin
          if (en) node_p0 <= sum_c;
        end

        always_ff @(posedge Clk) begin
          if (Rst)     vld_p0 <= 1'b0;
          else if (en) vld_p0 <= g_lvl[lv-1].vld_p0;
        end
      end
    end
  endgenerate

  fp32_add u_bias (
    .a (g_lvl[LEVELS].node_p0),
    .b (BIAS),
    .y (bias_c)
  );

  // ---- bias stage ----
  always_ff @(posedge Clk) begin
    if (en) sum_p1 <= bias_c;
  end

  always_ff @(posedge Clk) begin
    if (Rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= g_lvl[LEVELS].vld_p0;
  end

  // ---- activation / output stage ----
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      data_out  <= activate(sum_p1);
      valid_out <= vld_p1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      pix_cnt <= '0;
    else if (valid_out && ready_in)
      pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
  end

  assign last_out = valid_out && (pix_cnt == LAST_PIX);

endmodule

// File: tb/tb_featuremap_reduce_act.sv
// Directed bench: three configurations of featuremap_reduce_act (leaky and
// ReLU at 32 lanes, linear with bias at 3 lanes), all with a 4x4 frame.
module tb_featuremap_reduce_act;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1023:0] data32 = '0;
  logic         valid32 = 1'b0;
  logic         ready_in_a = 1'b1;
  logic         ready_out_a, valid_out_a, last_a;
  logic [31:0]  data_out_a;
  logic         ready_out_r, valid_out_r, last_r;
  logic [31:0]  data_out_r;
  logic [95:0]  data3 = '0;
  logic         valid3 = 1'b0;
  logic         ready_in3 = 1'b1;
  logic         ready_out3, valid_out3, last3;
  logic [31:0]  data_out3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  featuremap_reduce_act #(.CH_IN(32), .DATA_WIDTH(32), .IMG_SIZE(4), .BIAS(32'h0),
                          .ACT_MODE(2), .LEAKY_SHIFT(3)) u_leaky (
    .Clk(clk), .Rst(rst), .data_in(data32), .valid_in(valid32), .ready_out(ready_out_a),
    .data_out(data_out_a), .valid_out(valid_out_a), .ready_in(ready_in_a), .last_out(last_a));

  featuremap_reduce_act #(.CH_IN(32), .DATA_WIDTH(32), .IMG_SIZE(4), .BIAS(32'h0),
                          .ACT_MODE(1), .LEAKY_SHIFT(3)) u_relu (
    .Clk(clk), .Rst(rst), .data_in(data32), .valid_in(valid32), .ready_out(ready_out_r),
    .data_out(data_out_r), .valid_out(valid_out_r), .ready_in(ready_in_a), .last_out(last_r));

  featuremap_reduce_act #(.CH_IN(3), .DATA_WIDTH(32), .IMG_SIZE(4), .BIAS(32'h3f000000),
                          .ACT_MODE(0), .LEAKY_SHIFT(3)) u_lin3 (
    .Clk(clk), .Rst(rst), .data_in(data3), .valid_in(valid3), .ready_out(ready_out3),
    .data_out(data_out3), .valid_out(valid_out3), .ready_in(ready_in3), .last_out(last3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Stream pixel k: every lane 2^(k%20); 32-lane sum is 2^(k%20+5).
  function automatic logic [31:0] lane_val(input int k);
    return {1'b0, 8'(127 + k % 20), 23'b0};
  endfunction

  function automatic logic [31:0] sum_val(input int k);
    return {1'b0, 8'(132 + k % 20), 23'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid32 = 1'b0; valid3 = 1'b0; ready_in_a = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic one_pixel32(input string tag, input logic [31:0] lane,
                             input logic [31:0] exp_leaky, input logic [31:0] exp_relu);
    int lat;
    @(negedge clk);
    data32 = {32{lane}}; valid32 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      valid32 = 1'b0;
      lat++;
    end while (!valid_out_a && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'd7);
    chk({tag, "_leaky"}, data_out_a, exp_leaky);
    chk({tag, "_relu_vld"}, {31'b0, valid_out_r}, 32'd1);
    chk({tag, "_relu"}, data_out_r, exp_relu);
  endtask

  task automatic one_pixel3(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] exp_val);
    int lat;
    @(negedge clk);
    data3 = {l2, l1, l0}; valid3 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      valid3 = 1'b0;
      lat++;
    end while (!valid_out3 && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_data"}, data_out3, exp_val);
  endtask

  task automatic stream(input string tag, input int n, input int stall_at, input int stall_len);
    int sent, got, extra;
    logic stalled_prev;
    logic [31:0] held;
    sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (got >= n) break;
      @(negedge clk);
      ready_in_a = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      valid32    = (sent < n);
      data32     = {32{lane_val(sent)}};
      #1;
      chk({tag, "_ready_out"}, {31'b0, ready_out_a}, {31'b0, !(valid_out_a && !ready_in_a)});
      if (stalled_prev) chk({tag, "_hold"}, data_out_a, held);
      if (valid_out_a && ready_in_a) begin
        got++;
        chk({tag, "_data"}, data_out_a, sum_val(got - 1));
        chk({tag, "_last"}, {31'b0, last_a}, {31'b0, (got % 16 == 0)});
      end
      stalled_prev = valid_out_a && !ready_in_a;
      held = data_out_a;
      if (valid32 && ready_out_a) sent++;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
    @(negedge clk);
    valid32 = 1'b0; ready_in_a = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_out_a) extra++;
    end
    chk({tag, "_no_dup"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int extra;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vout", {31'b0, valid_out_a}, 32'd0);
    chk("rst_dout", data_out_a, 32'h0);
    chk("rst_last", {31'b0, last_a}, 32'd0);
    chk("rst_rdy", {31'b0, ready_out_a}, 32'd1);
    chk("rst_relu", {29'b0, valid_out_r, last_r, ready_out_r}, 32'd1);
    chk("rst_lin3", {29'b0, valid_out3, last3, ready_out3}, 32'd1);
    rst = 1'b0;

    one_pixel32("sum_ones", 32'h3f800000, 32'h42000000, 32'h42000000);
    one_pixel32("neg_ones", 32'hbf800000, 32'hc0800000, 32'h00000000);

    one_pixel3("pad_bias", 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40d00000);
    one_pixel3("rne_up",   32'h3fc00000, 32'hbe800000, 32'h4b800000, 32'h4b800001);
    one_pixel3("rne_tie",  32'h4b800000, 32'h3f800000, 32'h00000000, 32'h4b800000);
    one_pixel3("cancel",   32'h40400000, 32'hc0400000, 32'hbf800000, 32'hbf000000);

    do_reset();
    stream("bp", 10, 8, 5);

    do_reset();
    stream("frame", 40, -1, 0);

    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid32 = 1'b1; data32 = {32{lane_val(c)}};
    end
    #1;
    chk("pre_rst_vout", {31'b0, valid_out_a}, 32'd1);
    @(negedge clk);
    valid32 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_vout", {31'b0, valid_out_a}, 32'd0);
    chk("midrst_dout", data_out_a, 32'h0);
    chk("midrst_last", {31'b0, last_a}, 32'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_out_a) extra++;
    end
    chk("midrst_stale", 32'(extra), 32'd0);
    stream("refr", 16, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
